// File: rtl/pos_add_seq.sv
// Word-serial wide unsigned adder: sums two WORD_BITS*N_WORDS-bit operands one slice per cycle.
// Optional build macro POS_ADD_SEQ_EARLY_EXIT_EN finishes once no carry or nonzero upper slices remain.

module pos_add #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   s
);
    assign s = {1'b0, a} + {1'b0, b};
endmodule

module pos_add_seq #(
    parameter int WORD_BITS = 4,
    parameter int N_WORDS   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_BITS*N_WORDS-1:0]     a,
    input  logic [WORD_BITS*N_WORDS-1:0]     b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_BITS*N_WORDS:0]       c,
    output logic                             busy
);
    localparam int W     = WORD_BITS * N_WORDS;
    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    if (N_WORDS < 1) begin : g_bad_n_words
        $error("pos_add_seq: N_WORDS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [W-1:0]         a_reg;
    logic [W-1:0]         b_reg;
    logic                 carry;
    logic [IDX_W-1:0]     idx;
    logic [W:0]           c_reg;

    int                   slice_base;
    logic [WORD_BITS-1:0] a_slice;
    logic [WORD_BITS-1:0] b_slice;
    logic [WORD_BITS-1:0] carry_vec;
    logic [WORD_BITS:0]   s1;
    logic [WORD_BITS:0]   s2;
    logic                 carry_new;
    logic                 last_slice;
    logic                 finish;
    logic [W:0]           c_next;

    // Two chained adders per slice: operand sum first, then fold in the registered carry.
    pos_add #(.WIDTH(WORD_BITS)) u_add_ab (
        .a (a_slice),
        .b (b_slice),
        .s (s1)
    );

    pos_add #(.WIDTH(WORD_BITS)) u_add_carry (
        .a (s1[WORD_BITS-1:0]),
        .b (carry_vec),
        .s (s2)
    );

    always_comb begin
        slice_base = int'(idx) * WORD_BITS;
        a_slice    = a_reg[slice_base +: WORD_BITS];
        b_slice    = b_reg[slice_base +: WORD_BITS];
        carry_vec  = '0;
        carry_vec[0] = carry;
    end

    // The two carries are mutually exclusive, so OR-ing them is exact.
    always_comb begin
        carry_new  = s1[WORD_BITS] | s2[WORD_BITS];
        last_slice = (idx == IDX_W'(N_WORDS - 1));
    end

`ifdef POS_ADD_SEQ_EARLY_EXIT_EN
    logic high_zero;

    // Any nonzero slice above the current one means more work remains.
    always_comb begin
        high_zero = 1'b1;
        for (int j = 0; j < N_WORDS; j++) begin
            if (j > int'(idx)) begin
                if (a_reg[j*WORD_BITS +: WORD_BITS] != '0 ||
                    b_reg[j*WORD_BITS +: WORD_BITS] != '0) begin
                    high_zero = 1'b0;
                end
            end
        end
        finish = last_slice || (!carry_new && high_zero);
    end
`else
    always_comb begin
        finish = last_slice;
    end
`endif

    always_comb begin
        c_next = c_reg;
        c_next[slice_base +: WORD_BITS] = s2[WORD_BITS-1:0];
        if (finish) begin
            c_next[W] = carry_new;
        end
    end

    // Control FSM; all handshake outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            c_reg     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= 1'b0;
                        idx      <= '0;
                        c_reg    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    c_reg <= c_next;
                    carry <= carry_new;
                    if (finish) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign c = c_reg;

endmodule

// File: tb/tb_pos_add_seq.sv
// Scoreboard bench for pos_add_seq (WORD_BITS=4, N_WORDS=4); honours POS_ADD_SEQ_EARLY_EXIT_EN.

module tb_pos_add_seq;
    localparam int WORD_BITS = 4;
    localparam int N_WORDS   = 4;
    localparam int W         = WORD_BITS * N_WORDS;
`ifdef POS_ADD_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   c;
    logic         busy;

    logic dir_ready  = 1'b1;
    logic rand_ready = 1'b1;
    logic rand_phase = 1'b0;
    assign out_ready = rand_phase ? rand_ready : dir_ready;

    typedef struct {
        logic [W:0] c;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   ov_cyc = 0;
    bit   in_flight = 1'b0;
    logic prev_ov = 1'b0;

    pos_add_seq #(.WORD_BITS(WORD_BITS), .N_WORDS(N_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
    end

    always @(posedge clk) begin
        #1;
        rand_ready = 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string name, input logic [W:0] act, input logic [W:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Slice-by-slice reference for the data-dependent finish edge.
    function automatic int model_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic       cy;
        logic [4:0] s;
        if (!EARLY) return N_WORDS;
        cy = 1'b0;
        for (int k = 0; k < N_WORDS - 1; k++) begin
            s  = {1'b0, av[k*4 +: 4]} + {1'b0, bv[k*4 +: 4]} + {4'd0, cy};
            cy = s[4];
            if (!cy && (av >> (4 * (k + 1))) == 0 && (bv >> (4 * (k + 1))) == 0) return k + 1;
        end
        return N_WORDS;
    endfunction

    // Monitor: tracks accepts, out_valid rise and pops the scoreboard on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            in_flight = 1'b0;
            prev_ov   = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                tests++;
                if (in_flight) begin
                    fails++;
                    $display("[TB] FAIL double_accept: got accept while busy, expected none");
                end
                in_flight  = 1'b1;
                accept_cyc = cyc + 1;
            end
            if (out_valid && !prev_ov) ov_cyc = cyc;
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_output: got c=0x%0h, expected no output", c);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sum", c, e.c);
                    checkInt("latency", ov_cyc - accept_cyc, e.lat);
                    checkOutput("done_in_ready", {16'd0, in_ready}, '0);
                end
                in_flight = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [W:0] exp_c, input int exp_lat);
        exp_t e;
        int   n;
        e.c   = exp_c;
        e.lat = exp_lat;
        sb.push_back(e);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    task automatic waitOutValid(input string name);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!out_valid) begin
            fails++;
            $display("[TB] FAIL %s: got out_valid=0, expected 1", name);
        end
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending results, expected 0", sb.size());
        end
    endtask

    initial begin
        logic [W-1:0] av;
        logic [W-1:0] bv;
        bit           stale;

        #12;
        checkOutput("reset_out_valid", {16'd0, out_valid}, '0);
        checkOutput("reset_busy", {16'd0, busy}, '0);
        checkOutput("reset_c", c, '0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", {16'd0, in_ready}, 17'd1);

        @(posedge clk);
        #1;
        applyStimulus(16'h1234, 16'h4321, 17'h05555, 4);
        waitOutValid("basic_ov");
        @(negedge clk);
        checkOutput("basic_ov_one_cycle", {16'd0, out_valid}, '0);
        checkOutput("basic_in_ready_back", {16'd0, in_ready}, 17'd1);

        @(posedge clk);
        #1;
        applyStimulus(16'hFFFF, 16'h0001, 17'h10000, 4);
        applyStimulus(16'hFFFF, 16'hFFFF, 17'h1FFFE, 4);
        waitDrain(100);

        @(posedge clk);
        #1;
        dir_ready = 1'b0;
        applyStimulus(16'h00F0, 16'h0F10, 17'h01000, 4);
        fork
            applyStimulus(16'h0011, 16'h0022, 17'h00033, EARLY ? 2 : 4);
            begin
                waitOutValid("bp_ov");
                repeat (3) begin
                    checkOutput("bp_out_valid", {16'd0, out_valid}, 17'd1);
                    checkOutput("bp_in_ready", {16'd0, in_ready}, '0);
                    checkOutput("bp_c_stable", c, 17'h01000);
                    @(negedge clk);
                end
                dir_ready = 1'b1;
            end
        join
        waitDrain(100);

        @(posedge clk);
        #1;
        applyStimulus(16'h1234, 16'h1111, 17'h02345, 4);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", {16'd0, out_valid}, '0);
        checkOutput("async_rst_busy", {16'd0, busy}, '0);
        checkOutput("async_rst_c", c, '0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", {16'd0, in_ready}, 17'd1);
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        checkOutput("post_rst_no_stale", {16'd0, stale}, '0);
        @(posedge clk);
        #1;
        applyStimulus(16'h0001, 16'h0001, 17'h00002, EARLY ? 1 : 4);

        applyStimulus(16'h0003, 16'h0004, 17'h00007, EARLY ? 1 : 4);
        applyStimulus(16'h00FF, 16'h0001, 17'h00100, EARLY ? 3 : 4);
        waitDrain(100);

        rand_phase = 1'b1;
        for (int i = 0; i < 8; i++) begin
            av = W'($urandom) >> $urandom_range(0, 12);
            bv = W'($urandom) >> $urandom_range(0, 12);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            applyStimulus(av, bv, {1'b0, av} + {1'b0, bv}, model_lat(av, bv));
        end
        waitDrain(500);
        rand_phase = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
